// File: rtl/baud_pkg.sv
// Shared defaults and divide/increment helpers for the UART baud tick generator.
package baud_pkg;

  localparam int unsigned DEF_CLK_FREQ  = 100_000_000;
  localparam int unsigned DEF_BAUD_RATE = 9600;
  localparam int unsigned ACC_W         = 32;

  // Rounded integer divide ratio; a zero rate yields 0 so the caller can flag it.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate);
    if (baud_rate == 0) return 0;
    return (clk_freq + baud_rate / 2) / baud_rate;
  endfunction

  // round(baud_rate * 2^ACC_W / clk_freq), computed in 64 bits to avoid overflow.
  function automatic logic [ACC_W-1:0] calc_inc(input int unsigned clk_freq,
                                                input int unsigned baud_rate);
    longint unsigned num;
    if (clk_freq == 0) return '0;
    num = (64'(baud_rate) << ACC_W) + 64'(clk_freq / 2);
    return ACC_W'(num / 64'(clk_freq));
  endfunction

endpackage

// File: rtl/baud_unit.sv
// Baud-rate strobe generator: one-cycle baud pulse every DIV clocks.
// Define BAUD_UNIT_FRAC_EN to replace the divider with a 32-bit phase accumulator.
module baud_unit
  import baud_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = DEF_CLK_FREQ,
  parameter int unsigned BAUD_RATE = DEF_BAUD_RATE
) (
  input  logic clk,
  input  logic reset,
  output logic baud
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD_RATE);

  if (BAUD_RATE == 0) begin : g_err_zero_rate
    $error("baud_unit: BAUD_RATE must be non-zero");
  end
  if (64'(BAUD_RATE) * 64'd2 > 64'(CLK_FREQ)) begin : g_err_div_small
    $error("baud_unit: divide ratio below 2 (2*BAUD_RATE > CLK_FREQ)");
  end

`ifdef BAUD_UNIT_FRAC_EN

  localparam logic [ACC_W-1:0] INC = calc_inc(CLK_FREQ, BAUD_RATE);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum_c;

  assign sum_c = {1'b0, acc} + {1'b0, INC};

  // Carry-out of the phase add is the strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc  <= '0;
      baud <= 1'b0;
    end else begin
      acc  <= sum_c[ACC_W-1:0];
      baud <= sum_c[ACC_W];
    end
  end

`else

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;

  // Terminal count wraps to zero and fires the strobe on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      baud <= 1'b0;
    end else if (cnt == CNT_W'(DIV - 1)) begin
      cnt  <= '0;
      baud <= 1'b1;
    end else begin
      cnt  <= cnt + CNT_W'(1);
      baud <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_baud_unit.sv
// Self-checking bench for baud_unit: small-divider vector table plus default-rate sequences.
module tb_baud_unit;

  localparam int DIV_DEF = 10417;
  localparam int MAX_WAIT = 20000;

  logic clk = 1'b0;
  logic reset;
  logic baud;
  logic rs;
  logic baud_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  baud_unit dut (
    .clk   (clk),
    .reset (reset),
    .baud  (baud)
  );

  baud_unit #(.CLK_FREQ(100), .BAUD_RATE(25)) dut_s (
    .clk   (clk),
    .reset (rs),
    .baud  (baud_s)
  );

  typedef struct {
    logic rs;
    logic exp_baud;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Steps until baud is high; n = number of edges taken, -1 when the bound expires.
  task automatic wait_strobe(output int n);
    n = -1;
    for (int k = 1; k <= MAX_WAIT; k++) begin
      step();
      if (baud) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic add(input logic r, input logic e);
    vec_t v;
    v.rs = r;
    v.exp_baud = e;
    vecs.push_back(v);
  endtask

  task automatic add_run(input int zeros, input logic pulse);
    for (int i = 0; i < zeros; i++) add(1'b0, 1'b0);
    if (pulse) add(1'b0, 1'b1);
  endtask

  int n;
  int sum;

  initial begin
    reset = 1'b1;
    rs    = 1'b1;

    // DIV=4 divider: reset hold, steady pattern, reset mid-count and on the pulse edge.
    add(1'b1, 1'b0);
    add(1'b1, 1'b0);
    add_run(3, 1'b1);
    add_run(3, 1'b1);
    add_run(2, 1'b0);
    add(1'b1, 1'b0);
    add_run(3, 1'b1);
    add_run(3, 1'b0);
    add(1'b1, 1'b0);
    add_run(3, 1'b1);
    add_run(1, 1'b0);

    @(negedge clk);
    foreach (vecs[i]) begin
      rs = vecs[i].rs;
      step();
      chk($sformatf("small_vec%0d", i), int'(baud_s), int'(vecs[i].exp_baud));
    end
    rs = 1'b1;

    // Default instance held in reset the whole time above; confirm it stays quiet.
    for (int i = 0; i < 10; i++) begin
      step();
      chk("reset_hold", int'(baud), 0);
    end

    // First strobe after release.
    reset = 1'b0;
    wait_strobe(n);
    chk("first_strobe", n, DIV_DEF);

    // Steady period and single-cycle width.
    sum = 0;
    for (int p = 0; p < 4; p++) begin
      step();
      chk("pulse_width", int'(baud), 0);
      wait_strobe(n);
      if (n < 0) n = -2;
`ifdef BAUD_UNIT_FRAC_EN
      chk("frac_spacing_ok", int'(n + 1 == DIV_DEF - 1 || n + 1 == DIV_DEF), 1);
`else
      chk("period", n + 1, DIV_DEF);
`endif
      sum += n + 1;
    end
`ifdef BAUD_UNIT_FRAC_EN
    chk("frac_span4_ok", int'(sum >= 41665 && sum <= 41668), 1);
`else
    chk("span4", sum, 4 * DIV_DEF);
`endif

    // Reset 5000 cycles after a strobe: quiet during reset, phase realigned on release.
    for (int i = 0; i < 5000; i++) step();
    reset = 1'b1;
    step();
    chk("mid_reset_clear", int'(baud), 0);
    step();
    chk("mid_reset_hold", int'(baud), 0);
    reset = 1'b0;
    wait_strobe(n);
    chk("strobe_after_mid_reset", n, DIV_DEF);
    step();
    chk("pulse_width_after_reset", int'(baud), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
